capture_scheduler: RTL
======================

Name: capture_scheduler

Overview:
Sequences one motion-tracking cycle per frame-enable pulse. It arms on the frame-counter enable, waits for the next camera frame start, and streams one frame of pixels into the shared frame buffer. It then hands the buffer to the tracker and pushes the result to the DMX512 transmitter. It owns the frame-buffer ownership select between the camera writer and the tracker reader.

Parameters:
ADDR_W, 17, frame-buffer address width
FRAME_PIXELS, 76800, pixels per stored frame (320x240); capture never writes past this count
TO_W, 22, width of the tracker watchdog counter
TRACK_TIMEOUT, 2000000, clk cycles allowed between track_start and track_done

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync_in  in  1  camera vsync, asynchronous to clk, high during vertical blank
frame_enable  in  1  frame-counter enable, asynchronous to clk
pixel_valid  in  1  clk-domain strobe, one pixel available this cycle
wr_en  out  1  frame-buffer write enable
wr_addr  out  ADDR_W  frame-buffer write address
buf_owner  out  1  0 = camera writer owns buffer, 1 = tracker owns buffer
track_start  out  1  one-cycle pulse, tracker may begin
track_done  in  1  tracker finished, sampled only in PROCESS
dmx_update  out  1  one-cycle pulse, latch tracker result into DMX frame
dmx_busy  in  1  DMX transmitter mid-packet
frames_dropped  out  8  saturating count of ignored enable pulses
timeout_flag  out  1  sticky, tracker watchdog expired
state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state IDLE; wr_addr=0, wr_en=0, buf_owner=0, track_start=0, dmx_update=0, frames_dropped=0, timeout_flag=0, watchdog=0; synchronizer flops cleared.
- Reset mid-operation aborts immediately: wr_en is low from the first edge with reset sampled, and the interrupted frame is discarded.
- Input conditioning: vsync_in and frame_enable each pass through a 2-flop synchronizer plus edge register. fe_rise = rising edge of synced frame_enable; v_fall = frame start; v_rise = frame end. An async edge acts on state 3 clk later.
- IDLE: buf_owner=0. On fe_rise go to ARM.
- ARM: on v_fall go to CAPTURE and clear wr_addr to 0. A frame already in progress when armed is never captured partially.
- CAPTURE:
  - wr_en = pixel_valid while wr_addr < FRAME_PIXELS (combinational on registered state).
  - wr_addr increments after each write and saturates at FRAME_PIXELS; no wrap.
  - Exit to PROCESS on v_rise or when wr_addr reaches FRAME_PIXELS, whichever comes first. A short frame is legal.
  - If pixel_valid coincides with the exit event, that pixel is written only if wr_addr < FRAME_PIXELS.
- PROCESS:
  - On the entry cycle, track_start=1 for exactly one cycle; buf_owner=1 from the entry cycle onward; watchdog cleared.
  - Watchdog increments each cycle. track_done moves the FSM to UPDATE.
  - If the watchdog reaches TRACK_TIMEOUT-1 without track_done: set timeout_flag, go to IDLE, no dmx_update.
  - If track_done and the timeout occur in the same cycle, track_done wins.
- UPDATE: buf_owner stays 1. In the first cycle dmx_busy is sampled low, assert dmx_update for one cycle, then go to IDLE. Otherwise wait, with no timeout.
- fe_rise in any state other than IDLE is ignored and increments frames_dropped (saturates at 255). This includes the cycle the FSM returns to IDLE.
- track_done outside PROCESS is ignored.
- timeout_flag clears only on reset.
- State encoding: IDLE=0, ARM=1, CAPTURE=2, PROCESS=3, UPDATE=4; drives state_dbg.

Decomposition:
- Shared package: state encoding localparams, default FRAME_PIXELS/ADDR_W constants (shared with the frame-buffer and tracker blocks).
- One sub-module: sync_edge (2-flop synchronizer + rise/fall pulse outputs), instantiated for vsync_in and frame_enable.

Test Plan:
- Nominal capture: reset, fe pulse, vsync fall, 76800 pixel_valid strobes -> wr_addr 0..76799 on 76800 wr_en cycles, then track_start for 1 cycle, buf_owner=1, state_dbg=3.
- Handoff with DMX busy: track_done 100 cycles after track_start, dmx_busy high 50 more cycles -> single dmx_update pulse on the first busy-low cycle, then state_dbg=0, buf_owner=0.
- Short frame: vsync rise after 1000 pixels -> PROCESS entered with wr_addr=1000, and no wr_en after the exit.
- Dropped enables: 3 fe pulses during PROCESS -> frames_dropped=3; 300 pulses while busy -> frames_dropped=255.
- Watchdog: TRACK_TIMEOUT=1000, no track_done -> timeout_flag=1 at cycle 999 after track_start, back to IDLE, no dmx_update; timeout_flag stays set through the next cycle.
- Reset mid-capture at pixel 500 -> wr_en=0 and wr_addr=0 after the next edge, state IDLE; vsync edges alone do not restart capture until a new fe pulse.

Source files
------------

// File: rtl/capture_scheduler_pkg.sv
// capture_scheduler_pkg: state encoding and frame-buffer geometry shared with the buffer and tracker blocks
package capture_scheduler_pkg;

   localparam int DEF_ADDR_W       = 17;
   localparam int DEF_FRAME_PIXELS = 76800;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_PROCESS = 3'd3;
   localparam logic [2:0] ST_UPDATE  = 3'd4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/capture_scheduler_sync.sv
// sync_edge: two-flop synchronizer with an edge register producing one-cycle rise/fall pulses
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic meta, sync, prev;

   // metastability filter followed by the previous-value register for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/capture_scheduler.sv
// capture_scheduler: arms on frame enable, captures one camera frame, hands the buffer to the tracker, then updates DMX
module capture_scheduler
   import capture_scheduler_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int FRAME_PIXELS  = DEF_FRAME_PIXELS,
   parameter int TO_W          = 22,
   parameter int TRACK_TIMEOUT = 2000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync_in,
   input  logic              frame_enable,
   input  logic              pixel_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              buf_owner,
   output logic              track_start,
   input  logic              track_done,
   output logic              dmx_update,
   input  logic              dmx_busy,
   output logic [7:0]        frames_dropped,
   output logic              timeout_flag,
   output logic [2:0]        state_dbg
);

   localparam logic [ADDR_W-1:0] FP_LIMIT = ADDR_W'(FRAME_PIXELS);
   localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TRACK_TIMEOUT - 1);

   logic [2:0]      state, state_nxt;
   logic [TO_W-1:0] wd;
   logic            v_fall, v_rise, fe_rise, fe_fall_unused;
   logic            room, wd_expired;

   sync_edge u_vsync (
      .clk      (clk),
      .reset    (reset),
      .async_in (vsync_in),
      .rise     (v_rise),
      .fall     (v_fall)
   );

   sync_edge u_fe (
      .clk      (clk),
      .reset    (reset),
      .async_in (frame_enable),
      .rise     (fe_rise),
      .fall     (fe_fall_unused)
   );

   assign room        = wr_addr < FP_LIMIT;
   assign wd_expired  = wd == WD_LAST;
   assign wr_en       = (state == ST_CAPTURE) && pixel_valid && room;
   assign buf_owner   = (state == ST_PROCESS) || (state == ST_UPDATE);
   assign track_start = (state == ST_PROCESS) && (wd == '0);
   assign dmx_update  = (state == ST_UPDATE) && !dmx_busy;
   assign state_dbg   = state;

   // next-state selection; track_done is checked before the watchdog so it wins a tie
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    state_nxt = fe_rise ? ST_ARM : ST_IDLE;
         ST_ARM:     state_nxt = v_fall ? ST_CAPTURE : ST_ARM;
         ST_CAPTURE: state_nxt = (v_rise || !room) ? ST_PROCESS : ST_CAPTURE;
         ST_PROCESS: state_nxt = track_done ? ST_UPDATE : (wd_expired ? ST_IDLE : ST_PROCESS);
         ST_UPDATE:  state_nxt = dmx_busy ? ST_UPDATE : ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // write address restarts at frame start and stops at the frame size because wr_en drops there
   always_ff @(posedge clk) begin
      if (reset)                             wr_addr <= '0;
      else if ((state == ST_ARM) && v_fall)  wr_addr <= '0;
      else if (wr_en)                        wr_addr <= wr_addr + 1'b1;
   end

   // watchdog is zero on the PROCESS entry cycle and counts while the tracker runs
   always_ff @(posedge clk) begin
      if (reset)                    wd <= '0;
      else if (state != ST_PROCESS) wd <= '0;
      else                          wd <= wd + 1'b1;
   end

   // sticky tracker timeout, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)                                                   timeout_flag <= 1'b0;
      else if ((state == ST_PROCESS) && !track_done && wd_expired) timeout_flag <= 1'b1;
   end

   // enables that arrive while a cycle is in flight are counted, saturating at 255
   always_ff @(posedge clk) begin
      if (reset)                           frames_dropped <= 8'd0;
      else if (fe_rise && state != ST_IDLE) frames_dropped <= sat_inc8(frames_dropped);
   end

endmodule
